// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Build option: WB_RR_EN selects round-robin arbitration instead of
// fixed priority with the starvation override.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    SRC_EXEC = 1'b0,
    SRC_LONG = 1'b1
  } wb_src_e;

  // x0 is hardwired to zero, so a transfer aimed at it writes nothing
  function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback sources / issue logic and the
// arbiter. The master side drives requests and queries; the slave side
// (the arbiter) returns readies, busy bits and the regfile write port.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                  wb0_valid;
  logic                  wb0_ready;
  logic [REG_ADDR_W-1:0] wb0_rd;
  logic [XLEN-1:0]       wb0_data;

  logic                  wb1_valid;
  logic                  wb1_ready;
  logic [REG_ADDR_W-1:0] wb1_rd;
  logic [XLEN-1:0]       wb1_data;

  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;

  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [REG_ADDR_W-1:0] rdq;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  rd_busy;

  logic                  regwrite_o;
  logic [REG_ADDR_W-1:0] rd_o;
  logic [XLEN-1:0]       writedata_o;

  modport master (
    output wb0_valid, wb0_rd, wb0_data,
    output wb1_valid, wb1_rd, wb1_data,
    output issue_valid, issue_rd,
    output rs1_q, rs2_q, rdq,
    input  wb0_ready, wb1_ready,
    input  rs1_busy, rs2_busy, rd_busy,
    input  regwrite_o, rd_o, writedata_o
  );

  modport slave (
    input  wb0_valid, wb0_rd, wb0_data,
    input  wb1_valid, wb1_rd, wb1_data,
    input  issue_valid, issue_rd,
    input  rs1_q, rs2_q, rdq,
    output wb0_ready, wb1_ready,
    output rs1_busy, rs2_busy, rd_busy,
    output regwrite_o, rd_o, writedata_o
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register pending-write scoreboard. A bit is set when an instruction
// with that destination issues and cleared on the edge that retires the
// regfile write; a simultaneous set wins so a re-issue is never lost.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk_wb_arbiter,
  input  logic                  reset_wb_arbiter,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1_q,
  input  logic [REG_ADDR_W-1:0] rs2_q,
  input  logic [REG_ADDR_W-1:0] rdq,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy
);

  logic [NUM_REGS-1:1] busy;
  logic [NUM_REGS-1:0] busy_vec;

  // set/clear each tracked register; x0 has no storage at all
  always_ff @(posedge clk_wb_arbiter or negedge reset_wb_arbiter) begin
    if (!reset_wb_arbiter) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_valid && (set_rd == REG_ADDR_W'(i))) begin
          busy[i] <= 1'b1;
        end else if (clr_valid && (clr_rd == REG_ADDR_W'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // query ports read a vector whose bit 0 is tied low
  always_comb begin
    busy_vec = {busy, 1'b0};
    rs1_busy = busy_vec[rs1_q];
    rs2_busy = busy_vec[rs2_q];
    rd_busy  = busy_vec[rdq];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file. Source 0 is the execute
// pipeline, source 1 the long-latency unit. The winner is registered one
// cycle ahead of the regfile write port, and a busy scoreboard tracks
// pending destinations for the issue stage.
// Build option: WB_RR_EN -> round-robin arbitration (no starvation counter).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic               clk_wb_arbiter,
  input  logic               reset_wb_arbiter,
  regfile_wb_arbiter_if.slave wb
);

  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..15");
  end

  wb_req_t               req0;
  wb_req_t               req1;
  wb_req_t               win_req;
  logic                  grant0;
  logic                  grant1;
  logic                  xfer;

  logic                  regwrite_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       data_q;

`ifdef WB_RR_EN
  wb_src_e               rr_ptr;
`else
  logic [3:0]            starve_cnt;
  logic                  starve_hit;
  assign starve_hit = (starve_cnt == 4'(STARVE_MAX));
`endif

  assign req0 = '{rd: wb.wb0_rd, data: wb.wb0_data};
  assign req1 = '{rd: wb.wb1_rd, data: wb.wb1_data};

  // grant selection; nothing is granted while reset is held
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef WB_RR_EN
    if (wb.wb0_valid && wb.wb1_valid) begin
      grant0 = (rr_ptr == SRC_EXEC);
      grant1 = (rr_ptr == SRC_LONG);
    end else begin
      grant0 = wb.wb0_valid;
      grant1 = wb.wb1_valid;
    end
`else
    grant1 = wb.wb1_valid && (!wb.wb0_valid || starve_hit);
    grant0 = wb.wb0_valid && !grant1;
`endif
    if (!reset_wb_arbiter) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign xfer    = grant0 || grant1;
  assign win_req = grant1 ? req1 : req0;

  assign wb.wb0_ready = grant0;
  assign wb.wb1_ready = grant1;

`ifdef WB_RR_EN
  // preferred source flips only when both contend
  always_ff @(posedge clk_wb_arbiter or negedge reset_wb_arbiter) begin
    if (!reset_wb_arbiter) begin
      rr_ptr <= SRC_EXEC;
    end else if (wb.wb0_valid && wb.wb1_valid) begin
      rr_ptr <= (rr_ptr == SRC_EXEC) ? SRC_LONG : SRC_EXEC;
    end
  end
`else
  // count consecutive denials of a waiting long-latency source
  always_ff @(posedge clk_wb_arbiter or negedge reset_wb_arbiter) begin
    if (!reset_wb_arbiter) begin
      starve_cnt <= '0;
    end else if (wb.wb1_valid && !grant1) begin
      if (starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  // output stage: one registered write per granted non-x0 transfer
  always_ff @(posedge clk_wb_arbiter or negedge reset_wb_arbiter) begin
    if (!reset_wb_arbiter) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
    end else if (xfer && writes_reg(win_req.rd)) begin
      regwrite_q <= 1'b1;
      rd_q       <= win_req.rd;
      data_q     <= win_req.data;
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  assign wb.regwrite_o  = regwrite_q;
  assign wb.rd_o        = rd_q;
  assign wb.writedata_o = data_q;

  wb_scoreboard u_scoreboard (
    .clk_wb_arbiter   (clk_wb_arbiter),
    .reset_wb_arbiter (reset_wb_arbiter),
    .set_valid        (wb.issue_valid),
    .set_rd           (wb.issue_rd),
    .clr_valid        (regwrite_q),
    .clr_rd           (rd_q),
    .rs1_q            (wb.rs1_q),
    .rs2_q            (wb.rs2_q),
    .rdq              (wb.rdq),
    .rs1_busy         (wb.rs1_busy),
    .rs2_busy         (wb.rs2_busy),
    .rd_busy          (wb.rd_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with
// literal expectations, then randomized traffic compared every cycle
// against a behavioural model of grants, output writes and busy bits.
module tb_regfile_wb_arbiter;

  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst_n;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk_wb_arbiter   (clk),
    .reset_wb_arbiter (rst_n),
    .wb               (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // behavioural model state
  bit        m_busy [32];
  bit        m_rw;
  bit [4:0]  m_rd;
  bit [31:0] m_data;
  int        m_denied;
  bit        m_pref;

  function automatic bit q_busy(input bit [4:0] q);
    return (q != 0) && m_busy[q];
  endfunction

  // compare process: check on the falling edge, then advance the model
  always @(negedge clk) begin
    bit g0, g1, v0, v1;
    if (!rst_n) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_rw = 0; m_rd = 0; m_data = 0; m_denied = 0; m_pref = 0;
      check("rst_wb0_ready", 32'(bus.wb0_ready), 0);
      check("rst_wb1_ready", 32'(bus.wb1_ready), 0);
      check("rst_regwrite",  32'(bus.regwrite_o), 0);
      check("rst_rd_o",      32'(bus.rd_o), 0);
      check("rst_wdata",     bus.writedata_o, 0);
      check("rst_rs1_busy",  32'(bus.rs1_busy), 0);
    end else begin
      v0 = bus.wb0_valid;
      v1 = bus.wb1_valid;
`ifdef WB_RR_EN
      if (v0 && v1) begin
        g0 = (m_pref == 0);
        g1 = (m_pref == 1);
      end else begin
        g0 = v0;
        g1 = v1;
      end
`else
      g1 = v1 && (!v0 || m_denied == STARVE_MAX);
      g0 = v0 && !g1;
`endif
      check("wb0_ready",   32'(bus.wb0_ready), 32'(g0));
      check("wb1_ready",   32'(bus.wb1_ready), 32'(g1));
      check("regwrite_o",  32'(bus.regwrite_o), 32'(m_rw));
      check("rd_o",        32'(bus.rd_o), 32'(m_rd));
      check("writedata_o", bus.writedata_o, m_data);
      check("rs1_busy",    32'(bus.rs1_busy), 32'(q_busy(bus.rs1_q)));
      check("rs2_busy",    32'(bus.rs2_busy), 32'(q_busy(bus.rs2_q)));
      check("rd_busy",     32'(bus.rd_busy),  32'(q_busy(bus.rdq)));

      // next state: retire current write, then record new issue (set wins)
      if (m_rw) m_busy[m_rd] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
      if (g0 && bus.wb0_rd != 0) begin
        m_rw = 1; m_rd = bus.wb0_rd; m_data = bus.wb0_data;
      end else if (g1 && bus.wb1_rd != 0) begin
        m_rw = 1; m_rd = bus.wb1_rd; m_data = bus.wb1_data;
      end else begin
        m_rw = 0;
      end
      if (v1 && !g1) m_denied = (m_denied < 15) ? m_denied + 1 : 15;
      else           m_denied = 0;
      if (v0 && v1) m_pref = ~m_pref;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb0_valid = 0; bus.wb0_rd = 0; bus.wb0_data = 0;
    bus.wb1_valid = 0; bus.wb1_rd = 0; bus.wb1_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
    bus.rs1_q = 0; bus.rs2_q = 0; bus.rdq = 0;
  endtask

  function automatic bit [4:0] rand_rd();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
  endfunction

  initial begin
    bit [9:0] pat;
    bit t0, t1;
    rst_n = 1'b1;
    idle_inputs();
    #1 rst_n = 1'b0;

    // reset with both sources requesting
    bus.wb0_valid = 1; bus.wb0_rd = 5'd3; bus.wb0_data = 32'h11;
    bus.wb1_valid = 1; bus.wb1_rd = 5'd4; bus.wb1_data = 32'h22;
    @(negedge clk);
    @(negedge clk);
    check("d_rst_ready0", 32'(bus.wb0_ready), 0);
    check("d_rst_ready1", 32'(bus.wb1_ready), 0);
    check("d_rst_regwrite", 32'(bus.regwrite_o), 0);
    step();
    rst_n = 1'b1;

    // contention pattern after release
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("d_first_ready0", 32'(bus.wb0_ready), 1);
      if (i == 1) begin
        check("d_first_regwrite", 32'(bus.regwrite_o), 1);
        check("d_first_rd", 32'(bus.rd_o), 3);
        check("d_first_data", bus.writedata_o, 32'h11);
      end
      pat[i] = bus.wb1_ready;
      step();
    end
`ifdef WB_RR_EN
    check("d_grant_pattern", 32'(pat), 32'h2AA);
`else
    check("d_grant_pattern", 32'(pat), 32'h210);
`endif

    // single source 1
    bus.wb0_valid = 0;
    bus.wb1_valid = 1; bus.wb1_rd = 5'd5; bus.wb1_data = 32'hDEADBEEF;
    @(negedge clk);
    check("d_single_ready1", 32'(bus.wb1_ready), 1);
    check("d_single_ready0", 32'(bus.wb0_ready), 0);
    step();

    // x0 write plus x0 issue
    bus.wb1_valid = 0;
    bus.wb0_valid = 1; bus.wb0_rd = 5'd0; bus.wb0_data = 32'h55;
    bus.issue_valid = 1; bus.issue_rd = 5'd0; bus.rdq = 5'd0;
    @(negedge clk);
    check("d_single_regwrite", 32'(bus.regwrite_o), 1);
    check("d_single_rd", 32'(bus.rd_o), 5);
    check("d_single_data", bus.writedata_o, 32'hDEADBEEF);
    check("d_x0_ready0", 32'(bus.wb0_ready), 1);
    step();
    bus.wb0_valid = 0; bus.issue_valid = 0;
    @(negedge clk);
    check("d_x0_regwrite", 32'(bus.regwrite_o), 0);
    check("d_x0_rd_hold", 32'(bus.rd_o), 5);
    check("d_x0_data_hold", bus.writedata_o, 32'hDEADBEEF);
    check("d_x0_rd_busy", 32'(bus.rd_busy), 0);
    step();

    // scoreboard set then clear
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    bus.rs1_q = 5'd7; bus.rs2_q = 5'd7; bus.rdq = 5'd7;
    @(negedge clk);
    check("d_sb_before_set", 32'(bus.rs1_busy), 0);
    step();
    bus.issue_valid = 0;
    bus.wb0_valid = 1; bus.wb0_rd = 5'd7; bus.wb0_data = 32'h77;
    @(negedge clk);
    check("d_sb_set", 32'(bus.rs1_busy), 1);
    step();
    bus.wb0_valid = 0;
    @(negedge clk);
    check("d_sb_wr_cycle_rw", 32'(bus.regwrite_o), 1);
    check("d_sb_wr_cycle_busy", 32'(bus.rd_busy), 1);
    step();
    @(negedge clk);
    check("d_sb_cleared", 32'(bus.rs1_busy), 0);
    step();

    // re-issue during the clearing cycle keeps the bit
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    step();
    bus.issue_valid = 0;
    bus.wb0_valid = 1; bus.wb0_rd = 5'd7; bus.wb0_data = 32'h78;
    step();
    bus.wb0_valid = 0;
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    @(negedge clk);
    check("d_sb2_rw", 32'(bus.regwrite_o), 1);
    step();
    bus.issue_valid = 0;
    @(negedge clk);
    check("d_sb2_set_wins", 32'(bus.rs2_busy), 1);
    step();

    // randomized traffic with occasional mid-run reset
    idle_inputs();
    t0 = 0; t1 = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      if (!bus.wb0_valid || t0) begin
        bus.wb0_valid = ($urandom_range(0, 9) < 7);
        bus.wb0_rd    = rand_rd();
        bus.wb0_data  = $urandom;
      end
      if (!bus.wb1_valid || t1) begin
        bus.wb1_valid = ($urandom_range(0, 9) < 6);
        bus.wb1_rd    = rand_rd();
        bus.wb1_data  = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 3) == 0);
      bus.issue_rd    = rand_rd();
      bus.rs1_q = 5'($urandom_range(0, 15));
      bus.rs2_q = 5'($urandom_range(0, 15));
      bus.rdq   = 5'($urandom_range(0, 15));
      @(negedge clk);
      #1;
      t0 = bus.wb0_valid && bus.wb0_ready;
      t1 = bus.wb1_valid && bus.wb1_ready;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
